// File: rtl/pwm_multi_breathe.sv
// Multi-channel LED PWM controller: per-channel OFF / FIXED / BREATHE / BLINK modes,
// runtime configuration over a valid/ready port, duty changes applied only at period boundaries.
module pwm_multi_breathe #(
  parameter int CHANNELS    = 4,
  parameter int PWM_WIDTH   = 10,
  parameter int STEP_DIV    = 65536,
  parameter int BLINK_TICKS = 256
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_channel,
  input  logic [1:0]           cfg_mode,
  input  logic [PWM_WIDTH-1:0] cfg_level,
  output logic [CHANNELS-1:0]  out_pwm
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_FIXED   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SW-1:0]        step_cnt_q, step_cnt_d;
  logic                 cfg_ready_q;
  logic [CHANNELS-1:0]  out_pwm_q, out_pwm_d;
  logic [CHANNELS-1:0]  down_q, down_d;
  logic [CHANNELS-1:0]  phase_q, phase_d;
  mode_e                mode_q   [CHANNELS];
  mode_e                mode_d   [CHANNELS];
  logic [PWM_WIDTH-1:0] level_q  [CHANNELS];
  logic [PWM_WIDTH-1:0] level_d  [CHANNELS];
  logic [PWM_WIDTH-1:0] target_q [CHANNELS];
  logic [PWM_WIDTH-1:0] target_d [CHANNELS];
  logic [PWM_WIDTH-1:0] active_q [CHANNELS];
  logic [PWM_WIDTH-1:0] active_d [CHANNELS];
  logic [BW-1:0]        bcnt_q   [CHANNELS];
  logic [BW-1:0]        bcnt_d   [CHANNELS];

  logic step_tick;
  logic boundary;
  logic new_phase;

  assign step_tick = (step_cnt_q == SW'(STEP_DIV - 1));
  assign boundary  = (pwm_cnt_q == '1);
  assign cfg_ready = cfg_ready_q;
  assign out_pwm   = out_pwm_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
    out_pwm_d  = out_pwm_q;
    down_d     = down_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    level_d    = level_q;
    target_d   = target_q;
    active_d   = active_q;
    bcnt_d     = bcnt_q;
    new_phase  = 1'b0;

    for (int i = 0; i < CHANNELS; i++) begin
      out_pwm_d[i] = (pwm_cnt_q < active_q[i]);
      // Shadow copy sees the pre-tick target when a tick lands on the boundary.
      if (boundary) active_d[i] = target_q[i];

      if (cfg_valid && cfg_ready_q && (cfg_channel == 4'(i))) begin
        mode_d[i]  = mode_e'(cfg_mode);
        level_d[i] = cfg_level;
        unique case (mode_e'(cfg_mode))
          MODE_OFF:     target_d[i] = '0;
          MODE_FIXED:   target_d[i] = cfg_level;
          MODE_BREATHE: begin
            target_d[i] = '0;
            down_d[i]   = 1'b0;
          end
          MODE_BLINK:   begin
            target_d[i] = cfg_level;
            phase_d[i]  = 1'b1;
            bcnt_d[i]   = '0;
          end
        endcase
      end else if (step_tick) begin
        unique case (mode_q[i])
          MODE_BREATHE: begin
            if (!down_q[i]) begin
              if (target_q[i] >= level_q[i]) begin
                down_d[i] = 1'b1;
                if (target_q[i] != '0) target_d[i] = target_q[i] - 1'b1;
              end else begin
                target_d[i] = target_q[i] + 1'b1;
              end
            end else if (target_q[i] == '0) begin
              down_d[i] = 1'b0;
              if (level_q[i] != '0) target_d[i] = PWM_WIDTH'(1);
            end else begin
              target_d[i] = target_q[i] - 1'b1;
            end
          end
          MODE_BLINK: begin
            new_phase = phase_q[i];
            if (bcnt_q[i] == BW'(BLINK_TICKS - 1)) begin
              bcnt_d[i] = '0;
              new_phase = ~phase_q[i];
            end else begin
              bcnt_d[i] = bcnt_q[i] + 1'b1;
            end
            phase_d[i]  = new_phase;
            target_d[i] = new_phase ? level_q[i] : '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge aclk) begin
    // NOTE: the per-channel arrays are real control state, not a RAM, so they are
    // reset along with everything else.
    if (reset) begin
      pwm_cnt_q   <= '0;
      step_cnt_q  <= '0;
      cfg_ready_q <= 1'b0;
      out_pwm_q   <= '0;
      down_q      <= '0;
      phase_q     <= '0;
      mode_q      <= '{default: MODE_OFF};
      level_q     <= '{default: '0};
      target_q    <= '{default: '0};
      active_q    <= '{default: '0};
      bcnt_q      <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pwm_cnt_q   <= pwm_cnt_d;
      step_cnt_q  <= step_cnt_d;
      cfg_ready_q <= 1'b1;
      out_pwm_q   <= out_pwm_d;
      down_q      <= down_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      level_q     <= level_d;
      target_q    <= target_d;
      active_q    <= active_d;
      bcnt_q      <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_pwm_multi_breathe.sv
// Self-checking bench for pwm_multi_breathe: directed scenarios plus random config traffic,
// compared every cycle against a behavioural model driven by elapsed-cycle arithmetic.
module tb_pwm_multi_breathe;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int SD   = 4;
  localparam int BT   = 2;
  localparam int PMAX = 1 << W;

  logic          aclk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_channel;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_level;
  logic [CH-1:0] out_pwm;

  int n_checks = 0;
  int n_errors = 0;

  pwm_multi_breathe #(
    .CHANNELS(CH), .PWM_WIDTH(W), .STEP_DIV(SD), .BLINK_TICKS(BT)
  ) dut (
    .aclk(aclk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_channel(cfg_channel), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
    .out_pwm(out_pwm)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counters derived from cycles since reset, blink phase from ticks since write.
  int m_t;
  int m_mode   [CH];
  int m_level  [CH];
  int m_target [CH];
  int m_active [CH];
  int m_ticks  [CH];
  bit m_up     [CH];
  bit m_ready;
  logic [CH-1:0] m_out;

  always @(posedge aclk) begin
    if (reset) begin
      m_t = 0; m_ready = 0; m_out = '0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 0; m_level[i] = 0; m_target[i] = 0; m_active[i] = 0;
        m_ticks[i] = 0; m_up[i] = 1;
      end
    end else begin
      automatic int  pc   = m_t % PMAX;
      automatic bit  bnd  = (pc == PMAX - 1);
      automatic bit  tick = ((m_t % SD) == SD - 1);
      for (int i = 0; i < CH; i++) m_out[i] = (pc < m_active[i]);
      for (int i = 0; i < CH; i++) begin
        automatic bit wr = cfg_valid && m_ready && (int'(cfg_channel) == i);
        if (bnd) m_active[i] = m_target[i];
        if (wr) begin
          m_mode[i]  = int'(cfg_mode);
          m_level[i] = int'(cfg_level);
          case (m_mode[i])
            0: m_target[i] = 0;
            1: m_target[i] = m_level[i];
            2: begin m_target[i] = 0; m_up[i] = 1; end
            default: begin m_target[i] = m_level[i]; m_ticks[i] = 0; end
          endcase
        end else if (tick && m_mode[i] == 2) begin
          if (m_up[i]) begin
            if (m_target[i] >= m_level[i]) begin
              m_up[i] = 0;
              if (m_target[i] > 0) m_target[i]--;
            end else m_target[i]++;
          end else if (m_target[i] == 0) begin
            m_up[i] = 1;
            if (m_level[i] > 0) m_target[i] = 1;
          end else m_target[i]--;
        end else if (tick && m_mode[i] == 3) begin
          m_ticks[i]++;
          m_target[i] = (((m_ticks[i] / BT) % 2) == 0) ? m_level[i] : 0;
        end
      end
      m_ready = 1;
      m_t++;
    end
  end

  always @(negedge aclk) begin
    check("out_pwm", 32'(out_pwm), 32'(m_out));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  end

  task automatic write(input int ch, input int mode, input int lvl);
    cfg_valid   = 1'b1;
    cfg_channel = 4'(ch);
    cfg_mode    = 2'(mode);
    cfg_level   = W'(lvl);
    @(negedge aclk);
    cfg_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    int cnt [CH];
    int total;
    int budget;
    reset = 1'b1; cfg_valid = 1'b0; cfg_channel = '0; cfg_mode = '0; cfg_level = '0;

    // Reset behaviour
    repeat (3) begin
      @(negedge aclk);
      check("rst_out", 32'(out_pwm), 32'h0);
      check("rst_ready", 32'(cfg_ready), 32'h0);
    end
    reset = 1'b0;
    @(negedge aclk);
    check("ready_rise", 32'(cfg_ready), 32'h1);

    // Fixed duty 5 on ch1
    write(1, 1, 5);
    idle(40);
    for (int i = 0; i < CH; i++) cnt[i] = 0;
    repeat (PMAX) begin
      for (int i = 0; i < CH; i++) cnt[i] += int'(out_pwm[i]);
      @(negedge aclk);
    end
    check("fixed_ch1_duty", 32'(cnt[1]), 32'd5);
    check("fixed_ch0_low", 32'(cnt[0]), 32'd0);
    check("fixed_ch2_low", 32'(cnt[2]), 32'd0);
    check("fixed_ch3_low", 32'(cnt[3]), 32'd0);

    // Breathe ch0 level 3: no 16-cycle window carries more than 3 high cycles
    write(0, 2, 3);
    total = 0;
    repeat (12) begin
      cnt[0] = 0;
      repeat (PMAX) begin
        cnt[0] += int'(out_pwm[0]);
        @(negedge aclk);
      end
      total += cnt[0];
      check("breathe_le_level", 32'(cnt[0] <= 3), 32'd1);
    end
    check("breathe_active", 32'(total > 0), 32'd1);

    // Breathe with level 0 stays low
    write(0, 2, 0);
    idle(2 * PMAX);
    cnt[0] = 0;
    repeat (4 * PMAX) begin
      cnt[0] += int'(out_pwm[0]);
      @(negedge aclk);
    end
    check("breathe_lvl0_low", 32'(cnt[0]), 32'd0);

    // Blink ch2 level 8
    write(2, 3, 8);
    idle(8 * PMAX);

    // Invalid channel write
    write(5, 1, 9);
    idle(2 * PMAX);

    // Write to ch3 on a step-tick cycle after letting it ramp
    write(3, 2, 9);
    idle(3 * PMAX);
    while ((m_t % SD) != SD - 1) @(negedge aclk);
    write(3, 2, 9);
    idle(3 * PMAX);

    // Mid-run reset during a breathe ramp at target 2
    write(0, 2, 3);
    budget = 200;
    while (m_target[0] != 2 && budget > 0) begin
      @(negedge aclk);
      budget--;
    end
    check("ramp_reached_2", 32'(m_target[0]), 32'd2);
    reset = 1'b1;
    @(negedge aclk);
    check("midrst_out", 32'(out_pwm), 32'h0);
    check("midrst_ready", 32'(cfg_ready), 32'h0);
    reset = 1'b0;
    total = 0;
    repeat (4 * PMAX) begin
      total += int'(out_pwm != '0);
      @(negedge aclk);
    end
    check("post_reset_quiet", 32'(total), 32'd0);

    // Random config traffic, occasional reset
    repeat (1500) begin
      reset       = ($urandom_range(0, 199) == 0);
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_channel = 4'($urandom_range(0, 7));
      cfg_mode    = 2'($urandom_range(0, 3));
      cfg_level   = W'($urandom_range(0, PMAX - 1));
      @(negedge aclk);
    end
    reset = 1'b0; cfg_valid = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
